sl_slave_responder: RTL and testbench
=====================================

# sl_slave_responder

Fixed-latency slave endpoint for the same-latency (SL) interconnect tree. It terminates one `slave_req_N` / `slave_res_N` leg and executes reads and writes against a local register bank of `DEPTH` words. It returns exactly one `SL_RES` beat exactly `LATENCY` cycles after each accepted `SL_REQ` beat. The interconnect has no response arbitration and relies on every slave honouring this fixed latency.

## Interface
- `LATENCY`, default 2: request-to-response delay in cycles; legal range 1..8.
- `DEPTH`, default 16: number of `DATA_W`-bit words in the bank; power of two.
- `BASE`, default 0: word address of bank entry 0; must be `DEPTH`-aligned.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, synchronous and active-high. The name is kept for `.*` port compatibility with the interconnect cells.
- `req`, input, `SL_REQ`: request beat, with fields `valid`, `we`, `addr[SL_ADDR_W]`, `wdata[SL_DATA_W]`, plus `wstrb` when configured.
- `res`, output, `SL_RES`: response beat, with fields `valid`, `err`, `rdata[SL_DATA_W]`.

## Operation
- No backpressure. Every cycle with `req.valid=1` is accepted.
- Decode: `hit = (req.addr >= BASE) && (req.addr < BASE+DEPTH)`. The index is `req.addr - BASE`, truncated to `$clog2(DEPTH)` bits.
- Write (`we=1`, hit):
  - The bank word is updated at the accepting edge.
  - Response: `err=0`, `rdata=0`.
- Read (`we=0`, hit):
  - The bank word is sampled at the accepting edge, i.e. the value before any write in that same cycle (there is only one port, so no same-cycle conflict exists).
  - Response: `err=0`, `rdata` = the sampled word.
- Miss, read or write:
  - The bank is not modified.
  - Response: `err=1`, `rdata=0`.
- Ordering: a read accepted at cycle t+1 returns data written at cycle t.
- Response path: a `LATENCY`-deep shift pipe of {`valid`, `err`, `rdata`}.
  - The head of the pipe drives `res`.
  - Bubbles (`req.valid=0`) propagate as `res.valid=0`.
- `res.err` and `res.rdata` are zero whenever `res.valid=0`. The pipe zeroes payload on bubbles.
- Bank contents have no reset. Reads before the first write return X in simulation and are a bench error.

## Timing
- Latency: `req.valid` sampled at edge t produces `res.valid=1` during the cycle after edge t+`LATENCY`-1. Equivalently, the response is registered `LATENCY` edges after the request.
- Throughput: one beat per cycle, sustained indefinitely.
- Reset values: `res.valid=0`, `res.err=0`, `res.rdata=0`. All pipe stages are cleared.
- Reset mid-operation:
  - In-flight responses are discarded and never emitted.
  - A request presented in the same cycle as asserted reset is dropped and causes no bank write.
- First accepted request after reset deassertion: the request in the first cycle with `rst_n=0` is serviced normally.
- Responses occur in exact request order, with no reordering or coalescing.

## Configuration
- `SL_SLAVE_WSTRB_EN` defined:
  - `SL_REQ` carries `wstrb[SL_DATA_W/8]`.
  - A write updates only the bytes whose strobe bit is 1.
  - A write with `wstrb=0` still responds `err=0` and changes nothing.
  - Strobes are ignored on reads and misses.
- `SL_SLAVE_WSTRB_EN` undefined: there is no `wstrb` field, and every write updates the full word.
- The macro must be consistent between `sl_pkg` and this block.

## Structure
- `sl_pkg` holds:
  - `SL_ADDR_W` and `SL_DATA_W`;
  - the `SL_REQ` and `SL_RES` typedefs (packed structs), with the `wstrb` field under `SL_SLAVE_WSTRB_EN`;
  - `SL_MAX_LATENCY = 8`.
- Sub-module `sl_fixed_delay`:
  - Parameterised by `DEPTH` and payload width.
  - Synchronous active-high clear.
  - Used for the response pipe and reusable by other SL slaves.
- Bank: an unpacked array inferred as registers or distributed RAM, single write port, single read port.

## Test plan
- Back-to-back write then read, `BASE=0`, `LATENCY=2`:
  - Write addr 3 `0xDEADBEEF`, then read addr 3 on the next cycle.
  - Required: write ack (`valid=1`, `err=0`, `rdata=0`) at t+2, then `rdata=0xDEADBEEF` at t+3.
- Miss, `BASE=16`, `DEPTH=16`:
  - Write addr 40 `0x1234`, then read addr 40, then read addr 16.
  - Required: both addr-40 responses have `err=1`, `rdata=0`; addr 16 holds its prior value.
- Bubble pattern: valid sequence 1,0,1,1,0 with `LATENCY=3`. Required: `res.valid` equals 1,0,1,1,0 shifted by 3 cycles, and payload is 0 in bubble cycles.
- Reset mid-flight:
  - Issue 2 reads, assert `rst_n=1` for 1 cycle at t+1, `LATENCY=2`.
  - Required: no `res.valid` for either read, and `res` reads all-zero during and after reset.
- With `SL_SLAVE_WSTRB_EN`:
  - Write `0xFFFFFFFF`, then write `0x00000000` with `wstrb=4'b0101`, then read.
  - Required: read returns `0xFF00FF00`.
- `LATENCY=1` streaming: 16 consecutive writes then 16 reads across the full bank. Required: every response arrives exactly 1 cycle later with matching data.

Source files
------------

// File: rtl/sl_slave_responder_pkg.sv
// Shared types for the same-latency (SL) interconnect: request/response beats and byte-merge helper.
// The wstrb request field exists only when SL_SLAVE_WSTRB_EN is defined.
package sl_pkg;

    localparam int SL_ADDR_W      = 32;
    localparam int SL_DATA_W      = 32;
    localparam int SL_STRB_W      = SL_DATA_W / 8;
    localparam int SL_MAX_LATENCY = 8;

    typedef struct packed {
        logic                 valid;
        logic                 we;
        logic [SL_ADDR_W-1:0] addr;
        logic [SL_DATA_W-1:0] wdata;
`ifdef SL_SLAVE_WSTRB_EN
        logic [SL_STRB_W-1:0] wstrb;
`endif
    } SL_REQ;

    typedef struct packed {
        logic                 valid;
        logic                 err;
        logic [SL_DATA_W-1:0] rdata;
    } SL_RES;

    function automatic logic [SL_DATA_W-1:0] sl_merge_bytes(
        input logic [SL_DATA_W-1:0] old_word,
        input logic [SL_DATA_W-1:0] new_word,
        input logic [SL_STRB_W-1:0] strb
    );
        logic [SL_DATA_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < SL_STRB_W; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                merged[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sl_slave_responder_if.sv
// One SL slave leg: request beat from the tree, response beat back to it.
interface sl_slave_responder_if;
    import sl_pkg::*;

    SL_REQ req;
    SL_RES res;

    modport master (output req, input res);
    modport slave  (input req, output res);

endinterface

// File: rtl/sl_slave_responder_fixed_delay.sv
// sl_fixed_delay: DEPTH-stage shift pipe with synchronous clear, reusable by any SL slave.
module sl_fixed_delay #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift every stage by one per cycle; clear wipes anything in flight.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            stage_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/sl_slave_responder.sv
// Fixed-latency SL slave: register bank of DEPTH words, one response exactly LATENCY cycles per request.
// Optional byte strobes are enabled by defining SL_SLAVE_WSTRB_EN.
module sl_slave_responder
    import sl_pkg::*;
#(
    parameter int LATENCY = 2,   // 1..SL_MAX_LATENCY
    parameter int DEPTH   = 16,  // power of two
    parameter int BASE    = 0    // DEPTH-aligned word address
) (
    input  logic                 clk,
    input  logic                 rst_n,  // active-high synchronous reset despite the name
    sl_slave_responder_if.slave  sl
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SL_ADDR_W:0] LO_A = (SL_ADDR_W + 1)'(BASE);
    localparam logic [SL_ADDR_W:0] HI_A = (SL_ADDR_W + 1)'(BASE + DEPTH);

    logic [SL_DATA_W-1:0] bank_r [DEPTH];

    logic                 hit_s;
    logic                 wr_en_s;
    logic [IDX_W-1:0]     idx_s;
    logic [SL_DATA_W-1:0] rd_word_s;
    logic [SL_DATA_W-1:0] wr_word_s;
    SL_RES                rsp_s;
    SL_RES                pipe_out_s;

    // Address decode and the word the bank would take on a write this cycle.
    always_comb begin
        hit_s     = ({1'b0, sl.req.addr} >= LO_A) && ({1'b0, sl.req.addr} < HI_A);
        idx_s     = IDX_W'(sl.req.addr - LO_A[SL_ADDR_W-1:0]);
        rd_word_s = bank_r[idx_s];
        wr_en_s   = sl.req.valid && sl.req.we && hit_s;
`ifdef SL_SLAVE_WSTRB_EN
        wr_word_s = sl_merge_bytes(rd_word_s, sl.req.wdata, sl.req.wstrb);
`else
        wr_word_s = sl.req.wdata;
`endif
    end

    // Response beat entering the pipe; payload forced to zero on bubbles, misses and write acks.
    always_comb begin
        rsp_s = {$bits(SL_RES){1'b0}};
        if (sl.req.valid) begin
            rsp_s.valid = 1'b1;
            if (!hit_s) begin
                rsp_s.err   = 1'b1;
                rsp_s.rdata = {SL_DATA_W{1'b0}};
            end else if (!sl.req.we) begin
                rsp_s.err   = 1'b0;
                rsp_s.rdata = rd_word_s;
            end else begin
                rsp_s.err   = 1'b0;
                rsp_s.rdata = {SL_DATA_W{1'b0}};
            end
        end else begin
            rsp_s = {$bits(SL_RES){1'b0}};
        end
    end

    // Bank write port; contents deliberately unreset, and a request seen during reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n && wr_en_s) begin
            bank_r[idx_s] <= wr_word_s;
        end
    end

    sl_fixed_delay #(
        .DEPTH (LATENCY),
        .WIDTH ($bits(SL_RES))
    ) u_res_pipe (
        .clk  (clk),
        .clr  (rst_n),
        .din  (rsp_s),
        .dout (pipe_out_s)
    );

    assign sl.res = pipe_out_s;

endmodule

// File: tb/tb_sl_slave_responder.sv
// Directed bench for sl_slave_responder: three instances cover LATENCY 1/2/3 and a non-zero BASE.
module tb_sl_slave_responder;
  import sl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sl_slave_responder_if ifa ();
  sl_slave_responder_if ifb ();
  sl_slave_responder_if ifc ();

  sl_slave_responder #(.LATENCY(2), .DEPTH(16), .BASE(0))  dut_a (.clk(clk), .rst_n(rst_n), .sl(ifa));
  sl_slave_responder #(.LATENCY(3), .DEPTH(16), .BASE(16)) dut_b (.clk(clk), .rst_n(rst_n), .sl(ifb));
  sl_slave_responder #(.LATENCY(1), .DEPTH(16), .BASE(0))  dut_c (.clk(clk), .rst_n(rst_n), .sl(ifc));

  int n_cmp = 0;
  int n_bad = 0;

  bit          s_v  [40];
  bit          s_we [40];
  logic [31:0] s_a  [40];
  logic [31:0] s_wd [40];
  bit          e_v  [40];
  bit          e_err[40];
  logic [31:0] e_rd [40];
`ifdef SL_SLAVE_WSTRB_EN
  logic [3:0]  s_st [40];
  logic [3:0]  cur_strb = 4'hF;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int d, input bit v, input bit we, input logic [31:0] a, input logic [31:0] wd);
    SL_REQ r;
    r = {$bits(SL_REQ){1'b0}};
    r.valid = v;
    r.we    = we;
    r.addr  = a;
    r.wdata = wd;
`ifdef SL_SLAVE_WSTRB_EN
    r.wstrb = cur_strb;
`endif
    case (d)
      0:       ifa.req = r;
      1:       ifb.req = r;
      default: ifc.req = r;
    endcase
  endtask

  task automatic idle(input int d);
    drv(d, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  function automatic logic [63:0] res_of(input int d);
    SL_RES r;
    case (d)
      0:       r = ifa.res;
      1:       r = ifb.res;
      default: r = ifc.res;
    endcase
    return {30'd0, r.valid, r.err, r.rdata};
  endfunction

  task automatic put(input int i, input bit v, input bit we, input logic [31:0] a, input logic [31:0] wd,
                     input bit ev, input bit eerr, input logic [31:0] erd);
    s_v[i] = v; s_we[i] = we; s_a[i] = a; s_wd[i] = wd;
    e_v[i] = ev; e_err[i] = eerr; e_rd[i] = erd;
`ifdef SL_SLAVE_WSTRB_EN
    s_st[i] = 4'hF;
`endif
  endtask

  task automatic drive_row(input int d, input int i);
`ifdef SL_SLAVE_WSTRB_EN
    cur_strb = s_st[i];
`endif
    drv(d, s_v[i], s_we[i], s_a[i], s_wd[i]);
  endtask

  // Row j is expected on res right after the (j+L)-th edge of the run.
  task automatic run_seq(input int d, input int lat, input int n, input string name);
    logic [63:0] exp;
    drive_row(d, 0);
    for (int k = 0; k < n + lat; k++) begin
      int j;
      tick;
      j = k - (lat - 1);
      if (j >= 0 && j < n) exp = {30'd0, e_v[j], e_err[j], e_rd[j]};
      else                 exp = 64'd0;
      check($sformatf("%s[%0d]", name, k), res_of(d), exp);
      if (k + 1 < n) drive_row(d, k + 1);
      else           idle(d);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    idle(0); idle(1); idle(2);
    tick; tick;
    check("reset_a", res_of(0), 64'd0);
    check("reset_b", res_of(1), 64'd0);
    check("reset_c", res_of(2), 64'd0);
    rst_n = 1'b0;

    // write then read back-to-back, LATENCY=2
    put(0, 1'b1, 1'b1, 32'd3, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
    put(1, 1'b1, 1'b0, 32'd3, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF);
    run_seq(0, 2, 2, "wr_rd");

    // decode window 16..31, LATENCY=3; addr 32 must not alias onto entry 0
    put(0, 1'b1, 1'b1, 32'd16, 32'hCAFE0016, 1'b1, 1'b0, 32'h0);
    put(1, 1'b1, 1'b1, 32'd40, 32'h00001234, 1'b1, 1'b1, 32'h0);
    put(2, 1'b1, 1'b0, 32'd40, 32'h0,        1'b1, 1'b1, 32'h0);
    put(3, 1'b1, 1'b0, 32'd16, 32'h0,        1'b1, 1'b0, 32'hCAFE0016);
    put(4, 1'b1, 1'b0, 32'd15, 32'h0,        1'b1, 1'b1, 32'h0);
    put(5, 1'b1, 1'b1, 32'd32, 32'h55555555, 1'b1, 1'b1, 32'h0);
    put(6, 1'b1, 1'b0, 32'd16, 32'h0,        1'b1, 1'b0, 32'hCAFE0016);
    run_seq(1, 3, 7, "miss");

    // bubbles 1,0,1,1,0 with junk on the idle bus
    put(0, 1'b1, 1'b1, 32'd17, 32'hAAAA5555, 1'b1, 1'b0, 32'h0);
    put(1, 1'b0, 1'b1, 32'd17, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0);
    put(2, 1'b1, 1'b0, 32'd17, 32'h0,        1'b1, 1'b0, 32'hAAAA5555);
    put(3, 1'b1, 1'b1, 32'd18, 32'h0BADF00D, 1'b1, 1'b0, 32'h0);
    put(4, 1'b0, 1'b0, 32'd17, 32'h0,        1'b0, 1'b0, 32'h0);
    run_seq(1, 3, 5, "bubble");

    // reset while two reads are in flight
    drv(0, 1'b1, 1'b0, 32'd3, 32'h0);
    tick;
    check("rst_pre", res_of(0), 64'd0);
    drv(0, 1'b1, 1'b0, 32'd3, 32'h0);
    rst_n = 1'b1;
    tick;
    check("rst_during", res_of(0), 64'd0);
    rst_n = 1'b0;
    drv(0, 1'b1, 1'b0, 32'd3, 32'h0);
    tick;
    check("rst_dropped", res_of(0), 64'd0);
    idle(0);
    tick;
    check("rst_first_req", res_of(0), {30'd0, 1'b1, 1'b0, 32'hDEADBEEF});
    tick;
    check("rst_drain", res_of(0), 64'd0);

    // a write presented during reset must leave the bank untouched
    drv(0, 1'b1, 1'b1, 32'd3, 32'h0);
    rst_n = 1'b1;
    tick;
    rst_n = 1'b0;
    drv(0, 1'b1, 1'b0, 32'd3, 32'h0);
    tick;
    idle(0);
    tick;
    check("rst_no_write", res_of(0), {30'd0, 1'b1, 1'b0, 32'hDEADBEEF});

`ifdef SL_SLAVE_WSTRB_EN
    put(0, 1'b1, 1'b1, 32'd5, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0);
    put(1, 1'b1, 1'b1, 32'd5, 32'h00000000, 1'b1, 1'b0, 32'h0);
    s_st[1] = 4'b0101;
    put(2, 1'b1, 1'b1, 32'd5, 32'h12345678, 1'b1, 1'b0, 32'h0);
    s_st[2] = 4'b0000;
    put(3, 1'b1, 1'b0, 32'd5, 32'h0,        1'b1, 1'b0, 32'hFF00FF00);
    run_seq(0, 2, 4, "wstrb");
`else
    put(0, 1'b1, 1'b1, 32'd5, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0);
    put(1, 1'b1, 1'b1, 32'd5, 32'h12345678, 1'b1, 1'b0, 32'h0);
    put(2, 1'b1, 1'b0, 32'd5, 32'h0,        1'b1, 1'b0, 32'h12345678);
    run_seq(0, 2, 3, "full_word");
`endif

    // LATENCY=1 streaming over the whole bank
    for (int i = 0; i < 16; i++) begin
      put(i,      1'b1, 1'b1, 32'(i), 32'hC0DE0000 + 32'(i * 257), 1'b1, 1'b0, 32'h0);
      put(i + 16, 1'b1, 1'b0, 32'(i), 32'h0, 1'b1, 1'b0, 32'hC0DE0000 + 32'(i * 257));
    end
    run_seq(2, 1, 32, "stream");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
